// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and ALU drive/return bus for alu_issue_ctrl.
// The controller uses the slave modport; the instruction source / ALU side uses master.
interface alu_issue_ctrl_if #(parameter int DW = 32);
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_data;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [3:0]    alu_opcode;
  logic [3:0]    alu_cond;
  logic          alu_s;
  logic [2:0]    alu_sr_cont;
  logic [4:0]    alu_sr_bit;
  logic [15:0]   alu_imm;
  logic [DW-1:0] alu_out;
  logic [3:0]    alu_flags;

  modport master (
    output instr_valid, instr_data, alu_out, alu_flags,
    input  instr_ready, alu_in1, alu_in2, alu_opcode, alu_cond, alu_s,
           alu_sr_cont, alu_sr_bit, alu_imm
  );

  modport slave (
    input  instr_valid, instr_data, alu_out, alu_flags,
    output instr_ready, alu_in1, alu_in2, alu_opcode, alu_cond, alu_s,
           alu_sr_cont, alu_sr_bit, alu_imm
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: serial issue/writeback controller for the ALU.
// Accepts one instruction in IDLE, reads operands (READ), captures the ALU
// result (EXEC) and writes back register/flags (WB). Four cycles per instruction.
// Optional build macro ALU_ISSUE_R0_ZERO_EN: R0 reads as zero and writes to it are dropped.
module alu_issue_ctrl #(
  parameter int NREGS = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_issue_ctrl_if.slave bus,
  output logic [3:0]    flags_q,
  output logic          retire,
  output logic          illegal,
  input  logic [3:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t        state, state_nx;
  logic [31:0]   ir;
  logic [DW-1:0] regs [NREGS];
  logic [DW-1:0] result_q;
  logic [3:0]    flag_tmp;
  logic          cond_met_q;

  logic [3:0] f_cond, f_op, f_rd, f_rn, f_rm;
  logic       f_s;
  logic       is_illegal, writes_op, do_write, do_flags;

  assign f_cond = ir[31:28];
  assign f_op   = ir[27:24];
  assign f_s    = ir[23];
  assign f_rd   = ir[22:19];
  assign f_rn   = ir[18:15];
  assign f_rm   = ir[14:11];

  // Latched fields go straight to the ALU; they only change on the next accept.
  assign bus.alu_cond    = f_cond;
  assign bus.alu_opcode  = f_op;
  assign bus.alu_s       = f_s;
  assign bus.alu_sr_cont = ir[10:8];
  assign bus.alu_sr_bit  = ir[7:3];
  assign bus.alu_imm     = ir[15:0];

  function automatic logic [DW-1:0] rd_reg(input logic [3:0] a);
    logic [DW-1:0] v;
    v = '0;
    if (int'(a) < NREGS) v = regs[a];
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (a == 4'd0) v = '0;
`endif
    return v;
  endfunction

  // Flags are {N, Z, C, V}.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: return 1'b1;
      4'b0001: return z;
      4'b0010: return !z && (n == v);
      4'b0011: return n != v;
      4'b0100: return n == v;
      4'b0101: return z || (n != v);
      4'b0110: return cy && !z;
      4'b0111: return !cy;
      4'b1000: return cy;
      default: return 1'b0;
    endcase
  endfunction

  // Opcode classification and writeback qualification.
  always_comb begin
    is_illegal = (f_op == 4'b1000) || (f_op == 4'b1001) || (f_op == 4'b1010) ||
                 (f_op == 4'b1100) || (f_op == 4'b1111);
    writes_op  = (f_op <= 4'b0111) || (f_op == 4'b1101);
    do_write   = cond_met_q && writes_op && (int'(f_rd) < NREGS);
`ifdef ALU_ISSUE_R0_ZERO_EN
    if (f_rd == 4'd0) do_write = 1'b0;
`endif
    do_flags   = cond_met_q && !is_illegal && (f_s || (f_op == 4'b1011));
  end

  assign dbg_data = rd_reg(dbg_addr);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake/retire outputs.
  always_comb begin
    state_nx        = state;
    bus.instr_ready = 1'b0;
    retire          = 1'b0;
    illegal         = 1'b0;
    case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_nx = READ;
      end
      READ: state_nx = EXEC;
      EXEC: state_nx = WB;
      WB: begin
        retire   = 1'b1;
        illegal  = is_illegal;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: instruction latch, operand read, result capture, writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir          <= '0;
      bus.alu_in1 <= '0;
      bus.alu_in2 <= '0;
      result_q    <= '0;
      flag_tmp    <= '0;
      cond_met_q  <= 1'b0;
      flags_q     <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.instr_valid) ir <= bus.instr_data;
        READ: begin
          bus.alu_in1 <= rd_reg(f_rn);
          bus.alu_in2 <= rd_reg(f_rm);
        end
        EXEC: begin
          result_q   <= bus.alu_out;
          flag_tmp   <= bus.alu_flags;
          cond_met_q <= cond_ok(f_cond, flags_q);
        end
        WB: begin
          if (do_write) regs[f_rd] <= result_q;
          if (do_flags) flags_q    <= flag_tmp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: table of instructions with hand-computed
// expected register/flag results, a queue of expectations popped on retire,
// plus sequences for mid-instruction reset, R0 handling and debug-read timing.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  flags_q;
  logic        retire, illegal;
  logic [3:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl_if #(.DW(32)) bus ();

  alu_issue_ctrl #(.NREGS(16), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flags_q  (flags_q),
    .retire   (retire),
    .illegal  (illegal),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Stand-in ALU. A failed condition produces a junk value in place of high-Z.
  function automatic logic stub_cond(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'h0: return 1'b1;
      4'h1: return f[2];
      4'h2: return !f[2] && (f[3] == f[0]);
      4'h3: return f[3] != f[0];
      4'h4: return f[3] == f[0];
      4'h5: return f[2] || (f[3] != f[0]);
      4'h6: return f[1] && !f[2];
      4'h7: return !f[1];
      4'h8: return f[1];
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    logic [32:0] w;
    logic [31:0] r, a, b;
    logic c, v;
    a = bus.alu_in1;
    b = bus.alu_in2;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (bus.alu_opcode)
      4'h0: begin
        w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'h1, 4'hB: begin
        w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = ~w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'h6: r = {16'h0, bus.alu_imm};
      4'hD: r = b;
      4'hE: r = a;
      default: r = '0;
    endcase
    if (stub_cond(bus.alu_cond, flags_q)) begin
      bus.alu_out   = r;
      bus.alu_flags = {r[31], (r == 32'h0), c, v};
    end else begin
      bus.alu_out   = 32'hDEAD_BEEF;
      bus.alu_flags = 4'hF;
    end
  end

  typedef struct {
    logic [31:0] word;
    bit          hold;
    logic        ill;
    logic [3:0]  rd;
    logic [31:0] val;
    logic [3:0]  flags;
  } vec_t;

  typedef struct {
    logic        ill;
    logic [3:0]  rd;
    logic [31:0] val;
    logic [3:0]  flags;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[17];

  function automatic logic [31:0] enc(input logic [3:0] c, input logic [3:0] op, input logic s,
                                      input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm);
    return {c, op, s, rd, rn, rm, 11'b0};
  endfunction

  function automatic logic [31:0] movi(input logic [3:0] rd, input logic [15:0] imm);
    return {4'h0, 4'h6, 1'b0, rd, 3'b000, imm};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   n;
    bit   seen;
    exp_q.push_back('{ill: v.ill, rd: v.rd, val: v.val, flags: v.flags});
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = v.word;
    check($sformatf("v%0d ready_idle", idx), 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    // Busy: a held valid with a different word must not be taken.
    if (v.hold) bus.instr_data = movi(4'd2, 16'h0077);
    else        bus.instr_valid = 1'b0;
    check($sformatf("v%0d ready_busy", idx), 32'(bus.instr_ready), 32'd0);
    check($sformatf("v%0d retire_early", idx), 32'(retire), 32'd0);
    n = 1;
    seen = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      bus.instr_valid = 1'b0;
      if (retire) seen = 1;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL v%0d retire_timeout: got none expected retire", idx);
    end else begin
      check($sformatf("v%0d retire_lat", idx), 32'(n), 32'd3);
      check($sformatf("v%0d illegal", idx), 32'(illegal), 32'(e.ill));
    end
    dbg_addr = e.rd;
    @(negedge clk);
    check($sformatf("v%0d reg", idx), dbg_data, e.val);
    check($sformatf("v%0d flags", idx), 32'(flags_q), 32'(e.flags));
    check($sformatf("v%0d retire_pulse", idx), 32'(retire), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r0v;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;

    //            word                         hold ill rd     val            flags
    vecs[0]  = '{movi(4'd1, 16'd5),            0, 0, 4'd1,  32'd5,          4'h0};
    vecs[1]  = '{enc(4'h0,4'h0,1,4'd2,4'd1,4'd1), 1, 0, 4'd2,  32'd10,         4'h0};
    vecs[2]  = '{enc(4'h0,4'hB,0,4'd3,4'd1,4'd2), 0, 0, 4'd3,  32'd0,          4'h8};
    vecs[3]  = '{enc(4'h1,4'h0,1,4'd4,4'd1,4'd2), 0, 0, 4'd4,  32'd0,          4'h8};
    vecs[4]  = '{enc(4'h3,4'h0,0,4'd4,4'd1,4'd2), 0, 0, 4'd4,  32'd15,         4'h8};
    vecs[5]  = '{enc(4'h0,4'hF,1,4'd5,4'd1,4'd1), 0, 1, 4'd5,  32'd0,          4'h8};
    vecs[6]  = '{enc(4'h0,4'h1,1,4'd5,4'd2,4'd1), 0, 0, 4'd5,  32'd5,          4'h2};
    vecs[7]  = '{enc(4'h6,4'h0,1,4'd6,4'd2,4'd4), 0, 0, 4'd6,  32'd25,         4'h0};
    vecs[8]  = '{enc(4'h8,4'hD,0,4'd7,4'd0,4'd4), 0, 0, 4'd7,  32'd0,          4'h0};
    vecs[9]  = '{enc(4'h7,4'hD,0,4'd7,4'd0,4'd4), 0, 0, 4'd7,  32'd15,         4'h0};
    vecs[10] = '{enc(4'h0,4'h0,1,4'd1,4'd1,4'd2), 0, 0, 4'd1,  32'd15,         4'h0};
    vecs[11] = '{enc(4'h9,4'h0,0,4'd8,4'd1,4'd1), 0, 0, 4'd8,  32'd0,          4'h0};
    vecs[12] = '{enc(4'h0,4'hE,1,4'd1,4'd3,4'd0), 0, 0, 4'd1,  32'd15,         4'h4};
    vecs[13] = '{enc(4'h0,4'h8,0,4'd1,4'd1,4'd1), 0, 1, 4'd1,  32'd15,         4'h4};
    vecs[14] = '{enc(4'h4,4'h1,1,4'd10,4'd3,4'd1),0, 0, 4'd10, 32'hFFFF_FFF1,  4'h8};
    vecs[15] = '{enc(4'h2,4'h0,0,4'd11,4'd1,4'd1),0, 0, 4'd11, 32'd0,          4'h8};
    vecs[16] = '{enc(4'h5,4'h0,1,4'd11,4'd1,4'd1),0, 0, 4'd11, 32'd30,         4'h0};

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dbg_addr = 4'd5;
    #1;
    check("rst retire", 32'(retire), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    check("rst flags", 32'(flags_q), 32'd0);
    check("rst ready", 32'(bus.instr_ready), 32'd1);
    check("rst alu_in1", bus.alu_in1, 32'd0);
    check("rst alu_in2", bus.alu_in2, 32'd0);
    check("rst opcode", 32'(bus.alu_opcode), 32'd0);
    check("rst imm", 32'(bus.alu_imm), 32'd0);
    check("rst dbg", dbg_data, 32'd0);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Reset during EXEC of ADD R3=R1+R1: nothing written, everything cleared.
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = enc(4'h0, 4'h0, 1, 4'd3, 4'd1, 4'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dbg_addr = 4'd3;
    #1;
    check("mid_rst R3", dbg_data, 32'd0);
    check("mid_rst retire", 32'(retire), 32'd0);
    check("mid_rst flags", 32'(flags_q), 32'd0);
    dbg_addr = 4'd1;
    #1;
    check("mid_rst R1", dbg_data, 32'd0);
    @(negedge clk);
    check("mid_rst ready", 32'(bus.instr_ready), 32'd1);

    // R0 behaviour depends on the build option.
`ifdef ALU_ISSUE_R0_ZERO_EN
    r0v = '{movi(4'd0, 16'd7), 0, 0, 4'd0, 32'd0, 4'h0};
`else
    r0v = '{movi(4'd0, 16'd7), 0, 0, 4'd0, 32'd7, 4'h0};
`endif
    run_vec(100, r0v);

    // Debug read of the destination during WB shows the old value.
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = movi(4'd2, 16'd9);
    dbg_addr = 4'd2;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wb_dbg retire", 32'(retire), 32'd1);
    check("wb_dbg old", dbg_data, 32'd0);
    @(negedge clk);
    check("wb_dbg new", dbg_data, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
